// File: rtl/smul_accum.sv
// Multiply-accumulate back end: sums a programmed number of signed products into a wide accumulator.
// Optional saturating arithmetic with a sticky ovf flag when SMUL_ACCUM_SAT_EN is defined.
module smul_accum #(
  parameter int unsigned DATAWIDTH = 64,
  parameter int unsigned ACCWIDTH  = 136,
  parameter int unsigned CNTWIDTH  = 8
) (
  input  logic                     Clk,
  input  logic                     Rst,
  input  logic                     start,
  input  logic [CNTWIDTH-1:0]      len,
  input  logic [2*DATAWIDTH-1:0]   prod,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic [ACCWIDTH-1:0]      acc_out,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     busy
`ifdef SMUL_ACCUM_SAT_EN
  ,
  output logic                     ovf
`endif
);

  localparam int unsigned PRODW = 2 * DATAWIDTH;
  localparam int unsigned SUMW  = ACCWIDTH + 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t                      state_q, state_d;
  logic signed [ACCWIDTH-1:0]  acc_q, acc_d, sum_c;
  logic [CNTWIDTH-1:0]         rem_q, rem_d;
  logic [ACCWIDTH-1:0]         res_d;
  logic                        hs_c;

  assign hs_c = in_valid & in_ready;

`ifdef SMUL_ACCUM_SAT_EN
  localparam logic [ACCWIDTH-1:0] ACC_MAX = {1'b0, {(ACCWIDTH-1){1'b1}}};
  localparam logic [ACCWIDTH-1:0] ACC_MIN = {1'b1, {(ACCWIDTH-1){1'b0}}};

  logic signed [SUMW-1:0] sum_wide;
  logic                   sat_c;
  logic                   ovf_d;

  // One extra bit holds the true sum; top two bits disagreeing means out of range.
  assign sum_wide = SUMW'(acc_q) + SUMW'(signed'(prod));
  assign sat_c    = sum_wide[SUMW-1] ^ sum_wide[SUMW-2];
  assign sum_c    = sat_c ? (sum_wide[SUMW-1] ? signed'(ACC_MIN) : signed'(ACC_MAX))
                          : sum_wide[ACCWIDTH-1:0];
`else
  assign sum_c = acc_q + ACCWIDTH'(signed'(prod));
`endif

  // Next-state and datapath update
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    rem_d   = rem_q;
    res_d   = acc_out;
`ifdef SMUL_ACCUM_SAT_EN
    ovf_d   = ovf;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          acc_d = '0;
`ifdef SMUL_ACCUM_SAT_EN
          ovf_d = 1'b0;
`endif
          if (len == '0) begin
            state_d = DONE;
            res_d   = '0;
          end else begin
            state_d = ACCUM;
            rem_d   = len;
          end
        end
      end
      ACCUM: begin
        if (hs_c) begin
          acc_d = sum_c;
          rem_d = rem_q - CNTWIDTH'(1);
`ifdef SMUL_ACCUM_SAT_EN
          ovf_d = ovf | sat_c;
`endif
          if (rem_q == CNTWIDTH'(1)) begin
            state_d = DONE;
            res_d   = sum_c;
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (Rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Outputs are registered from the next-state decode so they line up with the state.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      acc_q     <= '0;
      rem_q     <= '0;
      acc_out   <= '0;
      in_ready  <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
`ifdef SMUL_ACCUM_SAT_EN
      ovf       <= 1'b0;
`endif
    end else begin
      acc_q     <= acc_d;
      rem_q     <= rem_d;
      acc_out   <= res_d;
      in_ready  <= (state_d == ACCUM);
      out_valid <= (state_d == DONE);
      busy      <= (state_d != IDLE);
`ifdef SMUL_ACCUM_SAT_EN
      ovf       <= ovf_d;
`endif
    end
  end

endmodule

// File: tb/tb_smul_accum.sv
// Scoreboard bench for smul_accum: a 24-bit instance for sequencing and a narrow 8-bit one for overflow.
module tb_smul_accum;

  localparam int unsigned DW = 8, AW = 24, CW = 8;
  localparam int unsigned SDW = 4, SAW = 8;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic              rst, start, in_valid, in_ready, out_valid, out_ready, busy;
  logic [CW-1:0]     len;
  logic [2*DW-1:0]   prod;
  logic [AW-1:0]     acc_out;
  logic              s_start, s_in_valid, s_in_ready, s_out_valid, s_out_ready, s_busy;
  logic [CW-1:0]     s_len;
  logic [2*SDW-1:0]  s_prod;
  logic [SAW-1:0]    s_acc;
`ifdef SMUL_ACCUM_SAT_EN
  logic              ovf, s_ovf;
`endif

  smul_accum #(.DATAWIDTH(DW), .ACCWIDTH(AW), .CNTWIDTH(CW)) dut (
    .Clk(Clk), .Rst(rst), .start(start), .len(len), .prod(prod), .in_valid(in_valid),
    .in_ready(in_ready), .acc_out(acc_out), .out_valid(out_valid), .out_ready(out_ready),
    .busy(busy)
`ifdef SMUL_ACCUM_SAT_EN
    , .ovf(ovf)
`endif
  );

  smul_accum #(.DATAWIDTH(SDW), .ACCWIDTH(SAW), .CNTWIDTH(CW)) dut_s (
    .Clk(Clk), .Rst(rst), .start(s_start), .len(s_len), .prod(s_prod), .in_valid(s_in_valid),
    .in_ready(s_in_ready), .acc_out(s_acc), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .busy(s_busy)
`ifdef SMUL_ACCUM_SAT_EN
    , .ovf(s_ovf)
`endif
  );

  typedef struct {
    longint val;
    bit     ovf;
  } exp_t;

  exp_t q[$];
  exp_t sq[$];
  int   checks = 0;
  int   failures = 0;

  task automatic check(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // Reference: plain integer sum of the terms, clamped per step when saturating, reduced to w bits.
  function automatic exp_t model(input longint p[$], input int w);
    exp_t   e;
    longint s;
`ifdef SMUL_ACCUM_SAT_EN
    longint hi, lo;
    hi = (longint'(1) <<< (w - 1)) - 1;
    lo = -(longint'(1) <<< (w - 1));
`endif
    s = 0;
    e.ovf = 1'b0;
    foreach (p[i]) begin
      s += p[i];
`ifdef SMUL_ACCUM_SAT_EN
      if (s > hi) begin s = hi; e.ovf = 1'b1; end
      else if (s < lo) begin s = lo; e.ovf = 1'b1; end
`endif
    end
    e.val = s & ((longint'(1) <<< w) - 1);
    return e;
  endfunction

  // Monitors: compare the result at the cycle the consumer takes it.
  exp_t me, se;
  always @(negedge Clk) begin
    if (!rst && out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++; failures++;
        $display("FAIL result_unexpected actual=0x%0h expected=none", acc_out);
      end else begin
        me = q.pop_front();
        check("result", longint'(acc_out), me.val);
`ifdef SMUL_ACCUM_SAT_EN
        check("ovf", longint'(ovf), longint'(me.ovf));
`endif
      end
    end
  end

  always @(negedge Clk) begin
    if (!rst && s_out_valid && s_out_ready) begin
      if (sq.size() == 0) begin
        checks++; failures++;
        $display("FAIL s_result_unexpected actual=0x%0h expected=none", s_acc);
      end else begin
        se = sq.pop_front();
        check("s_result", longint'(s_acc), se.val);
`ifdef SMUL_ACCUM_SAT_EN
        check("s_ovf", longint'(s_ovf), longint'(se.ovf));
`endif
      end
    end
  end

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  // gap_pct < 0 alternates in_valid 1,0,1,0...
  task automatic big_op(input longint p[$], input int gap_pct, input int hold, input bit start_in_done);
    int   n, got, guard;
    bit   hs;
    exp_t e;
    n = p.size();
    got = 0;
    guard = 0;
    e = model(p, AW);
    start = 1'b1;
    len = CW'(n);
    q.push_back(e);
    tick();
    start = 1'b0;
    len = CW'($urandom);
    if (n == 0) begin
      in_valid = 1'b1;
      prod = 16'($urandom);
      @(negedge Clk);
      check("len0_in_ready", longint'(in_ready), 0);
      check("len0_out_valid", longint'(out_valid), 1);
      tick();
      in_valid = 1'b0;
    end else begin
      while (got < n && guard < 1000) begin
        prod = 16'(p[got]);
        in_valid = (gap_pct < 0) ? (guard % 2 == 0) : ($urandom_range(99) >= 32'(gap_pct));
        @(negedge Clk);
        hs = in_valid && in_ready;
        tick();
        if (hs) got++;
        guard++;
      end
      in_valid = 1'b0;
      if (guard >= 1000) check("accum_timeout", longint'(got), longint'(n));
    end
    @(negedge Clk);
    check("latency_out_valid", longint'(out_valid), 1);
    check("done_in_ready", longint'(in_ready), 0);
    check("done_busy", longint'(busy), 1);
    tick();
    for (int h = 0; h < hold; h++) begin
      start = start_in_done && (h == 1);
      len = 8'd2;
      @(negedge Clk);
      check("held_out_valid", longint'(out_valid), 1);
      check("held_acc", longint'(acc_out), e.val);
      tick();
      start = 1'b0;
    end
    out_ready = 1'b1;
    start = start_in_done;
    @(negedge Clk);
    tick();
    out_ready = 1'b0;
    start = 1'b0;
    @(negedge Clk);
    check("idle_out_valid", longint'(out_valid), 0);
    check("idle_busy", longint'(busy), 0);
    check("acc_kept", longint'(acc_out), e.val);
    tick();
  endtask

  task automatic small_op(input longint p[$]);
    int  got, guard;
    bit  hs;
    got = 0;
    guard = 0;
    s_start = 1'b1;
    s_len = CW'(p.size());
    sq.push_back(model(p, SAW));
    tick();
    s_start = 1'b0;
    while (got < p.size() && guard < 200) begin
      s_prod = 8'(p[got]);
      s_in_valid = 1'b1;
      @(negedge Clk);
      hs = s_in_valid && s_in_ready;
      tick();
      if (hs) got++;
      guard++;
    end
    s_in_valid = 1'b0;
    guard = 0;
    do begin
      @(negedge Clk);
      guard++;
    end while (s_busy && guard < 50);
    if (guard >= 50) check("s_done_timeout", longint'(s_busy), 0);
    tick();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running expected=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    longint p[$];
    logic signed [2*DW-1:0]  r16;
    logic signed [2*SDW-1:0] r8;
    int guard;
    rst = 1'b1; start = 1'b0; len = '0; prod = '0; in_valid = 1'b0; out_ready = 1'b0;
    s_start = 1'b0; s_len = '0; s_prod = '0; s_in_valid = 1'b0; s_out_ready = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    @(negedge Clk);
    check("rst_acc_out", longint'(acc_out), 0);
    check("rst_in_ready", longint'(in_ready), 0);
    check("rst_out_valid", longint'(out_valid), 0);
    check("rst_busy", longint'(busy), 0);
    tick();

    p.delete(); p.push_back(6); p.push_back(-10); p.push_back(100);
    big_op(p, 0, 0, 1'b0);
    p.delete();
    big_op(p, 0, 1, 1'b0);
    p.delete(); p.push_back(1); p.push_back(2); p.push_back(3); p.push_back(4);
    big_op(p, -1, 5, 1'b1);

    // Abort after two of four handshakes.
    start = 1'b1; len = 8'd4;
    q.push_back(model(p, AW));
    tick();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      prod = 16'(i + 7);
      in_valid = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    rst = 1'b1;
    q.delete();
    tick();
    rst = 1'b0;
    @(negedge Clk);
    check("abort_acc_out", longint'(acc_out), 0);
    check("abort_in_ready", longint'(in_ready), 0);
    check("abort_out_valid", longint'(out_valid), 0);
    check("abort_busy", longint'(busy), 0);
    tick();
    p.delete(); p.push_back(-1);
    big_op(p, 0, 0, 1'b0);

    for (int k = 0; k < 10; k++) begin
      p.delete();
      for (int i = 0; i < int'($urandom_range(12)); i++) begin
        r16 = 16'($urandom);
        p.push_back(longint'(r16));
      end
      big_op(p, 30, int'($urandom_range(3)), 1'($urandom));
    end

    p.delete(); p.push_back(49); p.push_back(49); p.push_back(49);
    small_op(p);
    p.delete(); p.push_back(-49); p.push_back(-49); p.push_back(-49);
    small_op(p);
    for (int k = 0; k < 10; k++) begin
      p.delete();
      for (int i = 0; i < int'($urandom_range(6, 1)); i++) begin
        r8 = 8'($urandom);
        p.push_back(longint'(r8));
      end
      small_op(p);
    end

    guard = 0;
    while ((q.size() != 0 || sq.size() != 0) && guard < 100) begin
      tick();
      guard++;
    end
    check("drain_q", longint'(q.size()), 0);
    check("drain_sq", longint'(sq.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
